cart_loader: RTL and testbench

CART_LOADER -- requirements
Module: cart_loader

---
 rtl/cart_pkg.sv | 16 +
 rtl/cart_loader.sv | 117 +++++++++++
 tb/tb_cart_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cart_pkg.sv
// Shared definitions for the cartridge download path: loader FSM states and
// the ROM / detector address geometry.
package cart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int CART_MAX_BYTES = 32768;
  localparam int DET_ADDR_W     = 13;
  localparam int ROM_ADDR_W     = 15;
  localparam int CNT_W          = 16;

endpackage

// File: rtl/cart_loader.sv
// Cartridge image loader: writes downloaded bytes into ROM and forwards the
// leading DET_LIMIT bytes to the mapper detectors, then reports the image size.
module cart_loader
  import cart_pkg::*;
#(
  parameter int MAX_BYTES = CART_MAX_BYTES,
  parameter int DET_LIMIT = 8192
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  dl_start,
  input  logic                  dl_wr,
  input  logic [7:0]            dl_data,
  input  logic                  dl_done,
  output logic                  dl_ready,
  output logic                  rom_we,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic [7:0]            rom_wdata,
  output logic                  det_enable,
  output logic [DET_ADDR_W-1:0] det_addr,
  output logic [7:0]            det_data,
  output logic [31:0]           cart_size,
  output logic                  load_done,
  output logic                  overflow,
  output logic                  empty_err
);

  localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_BYTES);
  localparam logic [CNT_W:0] DET_C = (CNT_W+1)'(DET_LIMIT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             w_in_rom;
  logic             w_in_det;
  logic             w_finish;

  assign w_accept = dl_wr && (r_state == LOAD);
  assign w_in_rom = {1'b0, r_cnt} < MAX_C;
  assign w_in_det = {1'b0, r_cnt} < DET_C;
  assign w_finish = (r_state == LOAD) && dl_done && !dl_start;

  // Counter saturates at MAX_BYTES; a byte arriving with dl_done is still counted.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (dl_start) begin
      w_cnt_nxt = '0;
    end else if (w_accept && w_in_rom) begin
      w_cnt_nxt = r_cnt + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    dl_ready    = 1'b0;
    load_done   = 1'b0;
    case (r_state)
      IDLE: ;
      LOAD: begin
        dl_ready = 1'b1;
        if (dl_done) w_state_nxt = FINISH;
      end
      FINISH: begin
        load_done   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (dl_start) w_state_nxt = LOAD;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_wdata  <= '0;
      det_enable <= 1'b0;
      det_addr   <= '0;
      det_data   <= '0;
      cart_size  <= '0;
      overflow   <= 1'b0;
      empty_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      rom_we     <= w_accept && w_in_rom;
      det_enable <= w_accept && w_in_rom && w_in_det;
      if (w_accept && w_in_rom) begin
        rom_addr  <= r_cnt[ROM_ADDR_W-1:0];
        rom_wdata <= dl_data;
      end
      // Offset 0 re-arms the detectors, so the stream stops rather than wraps.
      if (w_accept && w_in_rom && w_in_det) begin
        det_addr <= r_cnt[DET_ADDR_W-1:0];
        det_data <= dl_data;
      end
      if (dl_start) begin
        overflow <= 1'b0;
      end else if (w_accept && !w_in_rom) begin
        overflow <= 1'b1;
      end
      // Size and empty flag are latched on entry to FINISH so they are valid with load_done.
      if (dl_start) begin
        cart_size <= '0;
        empty_err <= 1'b0;
      end else if (w_finish) begin
        cart_size <= {16'd0, w_cnt_nxt};
        if (w_cnt_nxt == '0) empty_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cart_loader.sv
// Randomized bench for cart_loader: drives downloads and compares the observed
// ROM / detector strobe streams and status against an image-level model.
module tb_cart_loader;

  localparam int MAX = 32768;
  localparam int DET = 8192;

  logic        clk = 1'b0;
  logic        reset_n, dl_start, dl_wr, dl_done;
  logic [7:0]  dl_data;
  logic        dl_ready, rom_we, det_enable, load_done, overflow, empty_err;
  logic [14:0] rom_addr;
  logic [7:0]  rom_wdata, det_data;
  logic [12:0] det_addr;
  logic [31:0] cart_size;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_q[$], exp_bytes[$];
  int rom_a[$], rom_d[$], rom_c[$];
  int det_a[$], det_d[$], det_c[$];
  int ld_cnt = 0, ld_size = 0, desync = 0;

  cart_loader #(.MAX_BYTES(MAX), .DET_LIMIT(DET)) dut (
    .clk(clk), .reset_n(reset_n), .dl_start(dl_start), .dl_wr(dl_wr),
    .dl_data(dl_data), .dl_done(dl_done), .dl_ready(dl_ready),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .det_enable(det_enable), .det_addr(det_addr), .det_data(det_data),
    .cart_size(cart_size), .load_done(load_done), .overflow(overflow),
    .empty_err(empty_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dl_wr && dl_ready) acc_q.push_back(cyc);
    if (rom_we) begin
      rom_a.push_back(int'(rom_addr)); rom_d.push_back(int'(rom_wdata)); rom_c.push_back(cyc);
    end
    if (det_enable) begin
      det_a.push_back(int'(det_addr)); det_d.push_back(int'(det_data)); det_c.push_back(cyc);
      if (!rom_we) desync++;
    end
    if (load_done) begin
      ld_cnt++;
      ld_size = int'(cart_size);
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    acc_q.delete(); exp_bytes.delete();
    rom_a.delete(); rom_d.delete(); rom_c.delete();
    det_a.delete(); det_d.delete(); det_c.delete();
    ld_cnt = 0;
    ld_size = -1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input int i, input bit rnd, input bit with_done);
    int b;
    b = rnd ? int'($urandom_range(0, 255)) : (i & 255);
    exp_bytes.push_back(b);
    dl_wr = 1'b1; dl_data = 8'(b); dl_done = with_done;
    step();
    dl_wr = 1'b0; dl_done = 1'b0;
  endtask

  task automatic run_load(input int n, input bit rnd, input bit gaps, input bit last_with_done);
    clear_obs();
    dl_start = 1'b1; step(); dl_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) step();
      send_byte(i, rnd, last_with_done && (i == n - 1));
    end
    if (!last_with_done || n == 0) begin
      dl_done = 1'b1; step(); dl_done = 1'b0;
    end
    repeat (3) step();
  endtask

  // Expected image: bytes beyond MAX are dropped, detector sees the first DET.
  task automatic verify_load(input string nm, input int n);
    int exp_rom, exp_det, errs;
    exp_rom = (n > MAX) ? MAX : n;
    exp_det = (exp_rom > DET) ? DET : exp_rom;
    check({nm, " accepted"}, acc_q.size(), n);
    check({nm, " rom strobes"}, rom_a.size(), exp_rom);
    check({nm, " det strobes"}, det_a.size(), exp_det);
    errs = 0;
    for (int i = 0; i < rom_a.size() && i < exp_rom; i++)
      if (rom_a[i] != i || rom_d[i] != exp_bytes[i] || i >= acc_q.size() || rom_c[i] != acc_q[i] + 1)
        errs++;
    check({nm, " rom content"}, errs, 0);
    errs = 0;
    for (int i = 0; i < det_a.size() && i < exp_det; i++)
      if (det_a[i] != i || det_d[i] != exp_bytes[i] || i >= acc_q.size() || det_c[i] != acc_q[i] + 1)
        errs++;
    check({nm, " det content"}, errs, 0);
    check({nm, " load_done pulses"}, ld_cnt, 1);
    check({nm, " size at done"}, ld_size, exp_rom);
    check({nm, " size held"}, cart_size, exp_rom);
    check({nm, " overflow"}, overflow, n > MAX);
    check({nm, " empty_err"}, empty_err, n == 0);
    check({nm, " det/rom desync"}, desync, 0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " dl_ready"}, dl_ready, 0);
    check({nm, " rom_we"}, rom_we, 0);
    check({nm, " det_enable"}, det_enable, 0);
    check({nm, " load_done"}, load_done, 0);
    check({nm, " rom_addr"}, rom_addr, 0);
    check({nm, " rom_wdata"}, rom_wdata, 0);
    check({nm, " det_addr"}, det_addr, 0);
    check({nm, " det_data"}, det_data, 0);
    check({nm, " cart_size"}, cart_size, 0);
    check({nm, " overflow"}, overflow, 0);
    check({nm, " empty_err"}, empty_err, 0);
  endtask

  initial begin
    int n, zeros;
    reset_n = 1'b0; dl_start = 1'b0; dl_wr = 1'b0; dl_done = 1'b0; dl_data = 8'h00;
    repeat (3) step();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    step();

    // Traffic in IDLE is ignored, including a stray dl_done.
    clear_obs();
    dl_wr = 1'b1; dl_data = 8'h5A;
    repeat (5) step();
    dl_wr = 1'b0; dl_done = 1'b1; step(); dl_done = 1'b0;
    repeat (3) step();
    check("idle rom strobes", rom_a.size(), 0);
    check("idle load_done", ld_cnt, 0);
    check("idle dl_ready", dl_ready, 0);

    run_load(4096, 1'b0, 1'b0, 1'b0);
    verify_load("load4096", 4096);

    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 300);
      run_load(n, 1'b1, 1'b1, k == 2);
      verify_load($sformatf("rand%0d", k), n);
    end

    run_load(2048, 1'b0, 1'b0, 1'b1);
    verify_load("done_with_byte", 2048);
    if (rom_a.size() == 2048) begin
      check("done_with_byte last addr", rom_a[2047], 2047);
      check("done_with_byte last data", rom_d[2047], 2047 & 255);
    end else begin
      check("done_with_byte last present", rom_a.size(), 2048);
    end

    run_load(0, 1'b0, 1'b0, 1'b0);
    verify_load("empty", 0);
    repeat (5) step();
    check("empty_err sticky", empty_err, 1);

    run_load(16384, 1'b0, 1'b0, 1'b0);
    verify_load("load16384", 16384);
    zeros = 0;
    foreach (det_a[i]) if (det_a[i] == 0) zeros++;
    check("load16384 det_addr zero strobes", zeros, 1);

    run_load(32770, 1'b0, 1'b0, 1'b0);
    verify_load("overflow", 32770);
    if (rom_a.size() > 0) check("overflow last rom_addr", rom_a[rom_a.size()-1], 32'h7FFF);
    else check("overflow rom writes present", rom_a.size(), MAX);
    repeat (5) step();
    check("overflow sticky", overflow, 1);

    // dl_start beats a simultaneous dl_done: load continues from zero.
    dl_start = 1'b1; step(); dl_start = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(i + 7, 1'b1, 1'b0);
    repeat (2) step();
    clear_obs();
    dl_start = 1'b1; dl_done = 1'b1; step(); dl_start = 1'b0; dl_done = 1'b0;
    check("start_wins dl_ready", dl_ready, 1);
    check("start_wins no done", load_done, 0);
    for (int i = 0; i < 5; i++) send_byte(i, 1'b1, 1'b0);
    dl_done = 1'b1; step(); dl_done = 1'b0;
    repeat (3) step();
    verify_load("start_wins", 5);

    // Reset in the middle of a load abandons it.
    clear_obs();
    dl_start = 1'b1; step(); dl_start = 1'b0;
    for (int i = 0; i < 100; i++) send_byte(i, 1'b1, 1'b0);
    reset_n = 1'b0; step();
    check_reset_outputs("midload reset");
    reset_n = 1'b1;
    repeat (4) step();
    check("midload no load_done", ld_cnt, 0);
    check("midload rom writes", rom_a.size(), 100);
    run_load(10, 1'b1, 1'b0, 1'b0);
    verify_load("after_reset", 10);
    if (det_a.size() > 0) check("after_reset first det_addr", det_a[0], 0);
    else check("after_reset det present", det_a.size(), 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
